// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 receiver with filtered clock, framing FSM, E0/F0 prefix decode and receive FIFO.
module ps2_rx_fifo #(
  parameter int DEPTH      = 8,
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT    = 5000,
  parameter int DECODE     = 1
) (
  input  logic                     clk,
  input  logic                     clrn,
  input  logic                     ps2_clk,
  input  logic                     ps2_data,
  input  logic                     nextdata_n,
  input  logic                     ovf_clr,
  output logic [7:0]               data,
  output logic                     ext,
  output logic                     brk,
  output logic                     ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     parity_err,
  output logic                     frame_err,
  output logic                     timeout
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3;
  logic [1:0] cks_q, dts_q;
  logic filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [1:0] st_q, st_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] sh_q, sh_d;
  logic par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
  logic perr_q, perr_d, ferr_q, ferr_d, tout_q, tout_d, ovf_q, ovf_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [9:0] mem_q [DEPTH];
  logic ck, bit_in, fall, tmo_hit, good, is_e0, is_f0, stored, push, pop, full;
  assign ck = cks_q[1];
  assign bit_in = dts_q[1];
  assign fcnt_d = (ck == filt_q || fcnt_q == FW'(FILTER_LEN - 1)) ? '0 : fcnt_q + FW'(1);
  assign filt_d = (ck != filt_q && fcnt_q == FW'(FILTER_LEN - 1)) ? ck : filt_q;
  assign fall = filt_q & ~filt_d;
  assign tmo_hit = st_q != IDLE && !fall && tmo_q == TW'(TIMEOUT - 1);
  always_comb begin
    st_d = st_q;
    idx_d = idx_q;
    sh_d = sh_q;
    par_d = par_q;
    tmo_d = (st_q == IDLE || fall) ? '0 : tmo_q + TW'(1);
    good = 1'b0;
    perr_d = 1'b0;
    ferr_d = 1'b0;
    tout_d = 1'b0;
    if (tmo_hit) begin
      st_d = IDLE;
      tmo_d = '0;
      tout_d = 1'b1;
    end else if (fall) begin
      case (st_q)
        IDLE: begin
          st_d = bit_in ? IDLE : DATA;
          idx_d = 3'd0;
        end
        DATA: begin
          sh_d = {bit_in, sh_q[7:1]};
          idx_d = idx_q + 3'd1;
          st_d = idx_q == 3'd7 ? PARITY : DATA;
        end
        PARITY: begin
          par_d = bit_in;
          st_d = STOP;
        end
        default: begin
          st_d = IDLE;
          good = bit_in & ^{sh_q, par_q};
          ferr_d = ~bit_in;
          perr_d = bit_in & ~^{sh_q, par_q};
        end
      endcase
    end
  end
  assign is_e0 = DECODE != 0 && sh_q == 8'hE0;
  assign is_f0 = DECODE != 0 && sh_q == 8'hF0;
  assign stored = good && !is_e0 && !is_f0;
  assign pop = cnt_q != '0 && !nextdata_n;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign push = stored && (!full || pop);
  assign ext_pend_d = (good && is_e0) ? 1'b1 : (stored || perr_d || ferr_d || tout_d) ? 1'b0 : ext_pend_q;
  assign brk_pend_d = (good && is_f0) ? 1'b1 : (stored || perr_d || ferr_d || tout_d) ? 1'b0 : brk_pend_q;
  assign ovf_d = (stored && !push) | (ovf_q & ~ovf_clr);
  assign wr_d = push ? wr_q + AW'(1) : wr_q;
  assign rd_d = pop ? rd_q + AW'(1) : rd_q;
  assign cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cks_q <= 2'b11;
      dts_q <= 2'b11;
      filt_q <= 1'b1;
      fcnt_q <= '0;
      st_q <= IDLE;
      idx_q <= '0;
      sh_q <= '0;
      par_q <= 1'b0;
      tmo_q <= '0;
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      tout_q <= 1'b0;
      ovf_q <= 1'b0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      cks_q <= {cks_q[0], ps2_clk};
      dts_q <= {dts_q[0], ps2_data};
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
      st_q <= st_d;
      idx_q <= idx_d;
      sh_q <= sh_d;
      par_q <= par_d;
      tmo_q <= tmo_d;
      ext_pend_q <= ext_pend_d;
      brk_pend_q <= brk_pend_d;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
      tout_q <= tout_d;
      ovf_q <= ovf_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) if (push) mem_q[wr_q] <= {ext_pend_q, brk_pend_q, sh_q};
  assign {ext, brk, data} = mem_q[rd_q];
  assign ready = cnt_q != '0;
  assign count = cnt_q;
  assign overflow = ovf_q;
  assign parity_err = perr_q;
  assign frame_err = ferr_q;
  assign timeout = tout_q;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: table-driven and scoreboard bench for ps2_rx_fifo.
module tb_ps2_rx_fifo;
  localparam int DEPTH = 8, FL = 4, TMO = 500;
  logic clk = 1'b0, clrn, ps2_clk, ps2_data, nextdata_n, ovf_clr;
  logic [7:0] data;
  logic ext, brk, ready, overflow, parity_err, frame_err, timeout;
  logic [$clog2(DEPTH):0] count;
  int pass_n = 0, total_n = 0, cyc = 0, perr_tot = 0, ferr_tot = 0, tout_tot = 0, tout_cyc = 0, last_fall = 0;
  logic [9:0] q [$];
  typedef struct {
    logic [7:0] b;
    bit pflip;
    bit stp;
    bit exp_push;
    logic [9:0] exp_entry;
    int exp_perr;
    int exp_ferr;
  } vec_t;
  vec_t vt [18];
  ps2_rx_fifo #(.DEPTH(DEPTH), .FILTER_LEN(FL), .TIMEOUT(TMO), .DECODE(1)) dut (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .nextdata_n(nextdata_n),
    .ovf_clr(ovf_clr), .data(data), .ext(ext), .brk(brk), .ready(ready), .count(count),
    .overflow(overflow), .parity_err(parity_err), .frame_err(frame_err), .timeout(timeout)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (parity_err) perr_tot <= perr_tot + 1;
    if (frame_err) ferr_tot <= ferr_tot + 1;
    if (timeout) begin
      tout_tot <= tout_tot + 1;
      tout_cyc <= cyc;
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else pass_n++;
  endtask
  task automatic send(input logic [7:0] b, input bit pflip, input bit stp, input int nbits);
    logic [10:0] fr;
    fr = {stp, ~^b ^ pflip, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk) ps2_data = fr[i];
      repeat (50) @(negedge clk);
      ps2_clk = 1'b0;
      last_fall = cyc;
      repeat (50) @(negedge clk);
      ps2_clk = 1'b1;
    end
    @(negedge clk) ps2_data = 1'b1;
    repeat (10) @(negedge clk);
  endtask
  task automatic drain();
    logic [9:0] e;
    while (q.size() > 0) begin
      e = q.pop_front();
      @(negedge clk);
      chk("ready_head", 32'(ready), 1);
      chk("head_entry", 32'({ext, brk, data}), 32'(e));
      nextdata_n = 1'b0;
      @(negedge clk) nextdata_n = 1'b1;
    end
    @(negedge clk);
    chk("ready_empty", 32'(ready), 0);
    chk("count_empty", 32'(count), 0);
  endtask
  initial begin
    int p0, f0, t0;
    logic [7:0] b;
    vt = '{
      '{8'h1C, 1'b0, 1'b1, 1'b1, 10'h01C, 0, 0},
      '{8'hE0, 1'b0, 1'b1, 1'b0, 10'h000, 0, 0},
      '{8'hF0, 1'b0, 1'b1, 1'b0, 10'h000, 0, 0},
      '{8'h75, 1'b0, 1'b1, 1'b1, 10'h375, 0, 0},
      '{8'h75, 1'b0, 1'b1, 1'b1, 10'h075, 0, 0},
      '{8'h1C, 1'b1, 1'b1, 1'b0, 10'h000, 1, 0},
      '{8'h1C, 1'b0, 1'b0, 1'b0, 10'h000, 0, 1},
      '{8'hF0, 1'b0, 1'b1, 1'b0, 10'h000, 0, 0},
      '{8'h29, 1'b1, 1'b1, 1'b0, 10'h000, 1, 0},
      '{8'h29, 1'b0, 1'b1, 1'b1, 10'h029, 0, 0},
      '{8'hE0, 1'b0, 1'b1, 1'b0, 10'h000, 0, 0},
      '{8'h1C, 1'b0, 1'b0, 1'b0, 10'h000, 0, 1},
      '{8'h1C, 1'b0, 1'b1, 1'b1, 10'h01C, 0, 0},
      '{8'hE1, 1'b0, 1'b1, 1'b1, 10'h0E1, 0, 0},
      '{8'hE0, 1'b0, 1'b1, 1'b0, 10'h000, 0, 0},
      '{8'h6B, 1'b0, 1'b1, 1'b1, 10'h26B, 0, 0},
      '{8'hF0, 1'b0, 1'b1, 1'b0, 10'h000, 0, 0},
      '{8'h6B, 1'b0, 1'b1, 1'b1, 10'h16B, 0, 0}
    };
    clrn = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    nextdata_n = 1'b1;
    ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_pulses", 32'({parity_err, frame_err, timeout}), 0);
    clrn = 1'b1;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 18; i++) begin
      p0 = perr_tot;
      f0 = ferr_tot;
      if (vt[i].exp_push) q.push_back(vt[i].exp_entry);
      send(vt[i].b, vt[i].pflip, vt[i].stp, 11);
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(q.size()));
      chk($sformatf("vec%0d_perr", i), 32'(perr_tot - p0), 32'(vt[i].exp_perr));
      chk($sformatf("vec%0d_ferr", i), 32'(ferr_tot - f0), 32'(vt[i].exp_ferr));
      drain();
    end
    for (int i = 0; i < 9; i++) begin
      b = 8'h30 + 8'(i);
      if (i < DEPTH) q.push_back({2'b00, b});
      send(b, 1'b0, 1'b1, 11);
    end
    chk("full_count", 32'(count), DEPTH);
    chk("full_overflow", 32'(overflow), 1);
    drain();
    chk("ovf_sticky", 32'(overflow), 1);
    @(negedge clk) ovf_clr = 1'b1;
    @(negedge clk) ovf_clr = 1'b0;
    chk("ovf_cleared", 32'(overflow), 0);
    t0 = tout_tot;
    send(8'h55, 1'b0, 1'b1, 5);
    for (int i = 0; i < TMO + 200 && tout_tot == t0; i++) @(negedge clk);
    @(negedge clk);
    chk("tout_pulses", 32'(tout_tot - t0), 1);
    chk("tout_latency_ok", 32'(tout_cyc - last_fall >= TMO + FL + 1 && tout_cyc - last_fall <= TMO + FL + 3), 1);
    chk("tout_no_push", 32'(count), 0);
    q.push_back(10'h029);
    send(8'h29, 1'b0, 1'b1, 11);
    drain();
    t0 = tout_tot;
    ps2_data = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk) ps2_clk = 1'b0;
      repeat (2) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (40) @(negedge clk);
    end
    ps2_data = 1'b1;
    repeat (TMO + 100) @(negedge clk);
    chk("glitch_no_tout", 32'(tout_tot - t0), 0);
    q.push_back(10'h01C);
    send(8'h1C, 1'b0, 1'b1, 11);
    drain();
    send(8'h11, 1'b0, 1'b1, 11);
    send(8'h22, 1'b0, 1'b1, 11);
    chk("pre_rst_count", 32'(count), 2);
    send(8'h33, 1'b0, 1'b1, 5);
    @(negedge clk) ps2_clk = 1'b0;
    repeat (10) @(negedge clk);
    clrn = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(ready), 0);
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_flags", 32'({overflow, parity_err, frame_err, timeout}), 0);
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1;
    @(negedge clk) clrn = 1'b1;
    repeat (5) @(negedge clk);
    q.push_back(10'h05A);
    send(8'h5A, 1'b0, 1'b1, 11);
    chk("post_rst_count", 32'(count), 1);
    drain();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
